// File: rtl/block_state_arbiter_pkg.sv
// Breakout field geometry shared by the renderer and game logic, plus the
// request encodings and FSM state type of the block-state arbiter.
package block_state_arbiter_pkg;

    localparam int BLOCK_ROWS      = 6;
    localparam int BLOCK_COLS      = 12;
    localparam int GEO_BLOCK_COUNT = BLOCK_ROWS * BLOCK_COLS;

    localparam logic REQ_OP_QUERY = 1'b0;
    localparam logic REQ_OP_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned count);
        return addr < count;
    endfunction

endpackage

// File: rtl/block_state_mem.sv
// Single-port 1-bit block-alive RAM, synchronous read-first, maps onto block RAM.
module block_state_mem #(
    parameter int DEPTH      = 72,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wdata,
    output logic                  rdata
);

    logic mem [DEPTH];

    // Read-first so a clear returns the pre-kill alive bit in the same access.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/block_state_arbiter.sv
// Shares the block-alive RAM between renderer (active video) and game-logic
// query/clear requests (blanking); runs the level-init sweep and alive count.
module block_state_arbiter
    import block_state_arbiter_pkg::*;
#(
    parameter int BLOCK_COUNT = GEO_BLOCK_COUNT,
    parameter int ADDR_WIDTH  = 7,
    parameter int COUNT_WIDTH = 7
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   RENDER_ACTIVE,
    input  logic [ADDR_WIDTH-1:0]  RENDER_ADDR,
    output logic                   RENDER_ALIVE,
    input  logic                   REQ,
    input  logic                   REQ_OP,
    input  logic [ADDR_WIDTH-1:0]  REQ_ADDR,
    output logic                   ACK,
    output logic                   ACK_ALIVE,
    input  logic                   LEVEL_INIT,
    output logic                   BUSY,
    output logic [COUNT_WIDTH-1:0] ALIVE_COUNT,
    output logic                   LEVEL_CLEAR
);

    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(BLOCK_COUNT - 1);
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(BLOCK_COUNT);

    arb_state_t             state;
    arb_state_t             state_next;
    logic [ADDR_WIDTH-1:0]  sweep_ptr;
    logic [COUNT_WIDTH-1:0] count_q;

    logic                   mem_en;
    logic                   mem_we;
    logic                   mem_wdata;
    logic                   mem_rdata;
    logic [ADDR_WIDTH-1:0]  mem_addr;

    logic                   render_ok;
    logic                   req_ok;
    logic                   sweep_free;
    logic                   sweep_last;
    logic                   issue;
    logic                   dec;

    logic                   render_vld_p1;
    logic                   req_ok_p1;
    logic                   req_clear_p1;

    assign render_ok  = addr_in_range(32'(RENDER_ADDR), BLOCK_COUNT);
    assign req_ok     = addr_in_range(32'(REQ_ADDR), BLOCK_COUNT);
    assign sweep_free = (state == ST_INIT) && !RENDER_ACTIVE;
    assign sweep_last = sweep_free && (sweep_ptr == LAST_ADDR) && !LEVEL_INIT;
    assign issue      = (state == ST_IDLE) && REQ && !RENDER_ACTIVE && !LEVEL_INIT;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: begin
                if (sweep_last) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (LEVEL_INIT) begin
                    state_next = ST_INIT;
                end else if (issue) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = LEVEL_INIT ? ST_INIT : ST_IDLE;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Port mux: renderer first, then the sweep, then a game request.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 1'b0;
        mem_addr  = RENDER_ADDR;
        if (RENDER_ACTIVE) begin
            mem_en = render_ok;
        end else if (state == ST_INIT) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = 1'b1;
            mem_addr  = sweep_ptr;
        end else if (issue) begin
            mem_en   = req_ok;
            mem_we   = req_ok && (REQ_OP == REQ_OP_CLEAR);
            mem_addr = REQ_ADDR;
        end

        ACK          = (state == ST_DONE) && !RESET;
        ACK_ALIVE    = ACK && req_ok_p1 && mem_rdata;
        dec          = ACK_ALIVE && req_clear_p1 && (count_q != '0);
        BUSY         = (state == ST_INIT);
        RENDER_ALIVE = render_vld_p1 && mem_rdata;
    end

    // Count shows the decrement in the ACK cycle so LEVEL_CLEAR rises with it.
    assign ALIVE_COUNT = count_q - COUNT_WIDTH'(dec);
    assign LEVEL_CLEAR = (ALIVE_COUNT == '0) && !BUSY;

    always_ff @(posedge CLK) begin
        if (RESET || LEVEL_INIT) begin
            sweep_ptr <= '0;
        end else if (sweep_free && (sweep_ptr != LAST_ADDR)) begin
            sweep_ptr <= sweep_ptr + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= '0;
        end else if (sweep_last) begin
            count_q <= FULL_COUNT;
        end else if (dec) begin
            count_q <= count_q - COUNT_WIDTH'(1);
        end
    end

    // Stage p0 -> p1: qualifiers travelling with the synchronous read data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            render_vld_p1 <= 1'b0;
        end else begin
            render_vld_p1 <= RENDER_ACTIVE && render_ok;
        end
    end

    always_ff @(posedge CLK) begin
        if (issue) begin
            req_ok_p1    <= req_ok;
            req_clear_p1 <= (REQ_OP == REQ_OP_CLEAR);
        end
    end

    block_state_mem #(
        .DEPTH      (BLOCK_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (CLK),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_block_state_arbiter.sv
// Directed bench for block_state_arbiter: reset/init sweep, query/clear,
// render arbitration, level clear, sweep restart, out-of-range and reset abort.
module tb_block_state_arbiter;
    import block_state_arbiter_pkg::*;

    localparam int NB = 72;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       RENDER_ACTIVE;
    logic [6:0] RENDER_ADDR;
    logic       RENDER_ALIVE;
    logic       REQ;
    logic       REQ_OP;
    logic [6:0] REQ_ADDR;
    logic       ACK;
    logic       ACK_ALIVE;
    logic       LEVEL_INIT;
    logic       BUSY;
    logic [6:0] ALIVE_COUNT;
    logic       LEVEL_CLEAR;

    int checks = 0;
    int passed = 0;
    int failed = 0;
    logic model [NB];
    int model_count;

    always #5 CLK = ~CLK;

    block_state_arbiter #(
        .BLOCK_COUNT (NB),
        .ADDR_WIDTH  (7),
        .COUNT_WIDTH (7)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .RENDER_ACTIVE (RENDER_ACTIVE),
        .RENDER_ADDR   (RENDER_ADDR),
        .RENDER_ALIVE  (RENDER_ALIVE),
        .REQ           (REQ),
        .REQ_OP        (REQ_OP),
        .REQ_ADDR      (REQ_ADDR),
        .ACK           (ACK),
        .ACK_ALIVE     (ACK_ALIVE),
        .LEVEL_INIT    (LEVEL_INIT),
        .BUSY          (BUSY),
        .ALIVE_COUNT   (ALIVE_COUNT),
        .LEVEL_CLEAR   (LEVEL_CLEAR)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_fill();
        for (int i = 0; i < NB; i++) model[i] = 1'b1;
        model_count = NB;
    endtask

    task automatic request(input logic op, input logic [6:0] addr, output int lat,
                           output logic alive, output logic [6:0] cnt, output logic lclr);
        REQ = 1'b1;
        REQ_OP = op;
        REQ_ADDR = addr;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ACK && lat < 300);
        alive = ACK_ALIVE;
        cnt = ALIVE_COUNT;
        lclr = LEVEL_CLEAR;
        REQ = 1'b0;
        tick();
    endtask

    initial begin
        int lat;
        int n;
        int c;
        int free_n;
        logic alive;
        logic lclr;
        logic ack_early;
        logic [6:0] cnt;

        RESET = 1'b1;
        RENDER_ACTIVE = 1'b0;
        RENDER_ADDR = '0;
        REQ = 1'b0;
        REQ_OP = REQ_OP_QUERY;
        REQ_ADDR = '0;
        LEVEL_INIT = 1'b0;
        tick();
        tick();
        RESET = 1'b0;

        check("rst_render_alive", 32'(RENDER_ALIVE), 0);
        check("rst_ack", 32'(ACK), 0);
        check("rst_ack_alive", 32'(ACK_ALIVE), 0);
        check("rst_count", 32'(ALIVE_COUNT), 0);
        check("rst_level_clear", 32'(LEVEL_CLEAR), 0);
        check("rst_busy", 32'(BUSY), 1);

        n = 0;
        while (BUSY && n < 500) begin
            n++;
            tick();
        end
        model_fill();
        check("rst_busy_cycles", n, 72);
        check("init_count", 32'(ALIVE_COUNT), 72);
        check("init_level_clear", 32'(LEVEL_CLEAR), 0);

        request(REQ_OP_QUERY, 7'd5, lat, alive, cnt, lclr);
        check("q5_latency", lat, 1);
        check("q5_alive", 32'(alive), 1);
        check("q5_count", 32'(cnt), 72);

        request(REQ_OP_CLEAR, 7'd10, lat, alive, cnt, lclr);
        model[10] = 1'b0;
        model_count--;
        check("clr10a_latency", lat, 1);
        check("clr10a_alive", 32'(alive), 1);
        check("clr10a_count", 32'(cnt), 71);
        request(REQ_OP_CLEAR, 7'd10, lat, alive, cnt, lclr);
        check("clr10b_alive", 32'(alive), 0);
        check("clr10b_count", 32'(cnt), 71);
        check("after_clr_count", 32'(ALIVE_COUNT), 71);

        RENDER_ACTIVE = 1'b1;
        RENDER_ADDR = 7'd10;
        tick();
        check("render10", 32'(RENDER_ALIVE), 0);
        RENDER_ADDR = 7'd11;
        tick();
        check("render11", 32'(RENDER_ALIVE), 1);
        RENDER_ADDR = 7'd100;
        tick();
        check("render100", 32'(RENDER_ALIVE), 0);
        RENDER_ACTIVE = 1'b0;
        RENDER_ADDR = 7'd11;
        tick();
        check("render_inactive", 32'(RENDER_ALIVE), 0);

        // Request held through a 100-cycle active window.
        RENDER_ACTIVE = 1'b1;
        REQ = 1'b1;
        REQ_OP = REQ_OP_QUERY;
        REQ_ADDR = 7'd20;
        ack_early = 1'b0;
        for (int i = 0; i < 100; i++) begin
            RENDER_ADDR = 7'(i);
            tick();
            if (ACK) ack_early = 1'b1;
            check("window_render", 32'(RENDER_ALIVE), (i < NB) ? 32'(model[i]) : 0);
        end
        check("window_no_ack", 32'(ack_early), 0);
        RENDER_ACTIVE = 1'b0;
        tick();
        check("window_ack", 32'(ACK), 1);
        check("window_ack_alive", 32'(ACK_ALIVE), 1);
        REQ = 1'b0;
        tick();

        for (int a = 0; a < NB; a++) begin
            request(REQ_OP_CLEAR, 7'(a), lat, alive, cnt, lclr);
            check("clrall_latency", lat, 1);
            check("clrall_alive", 32'(alive), 32'(model[a]));
            if (model[a]) begin
                model[a] = 1'b0;
                model_count--;
            end
            check("clrall_count", 32'(cnt), model_count);
            check("clrall_level_clear", 32'(lclr), (model_count == 0) ? 1 : 0);
        end
        check("cleared_level_clear", 32'(LEVEL_CLEAR), 1);

        LEVEL_INIT = 1'b1;
        tick();
        LEVEL_INIT = 1'b0;
        check("linit_busy", 32'(BUSY), 1);
        check("linit_level_clear", 32'(LEVEL_CLEAR), 0);
        n = 0;
        while (BUSY && n < 500) begin
            n++;
            tick();
        end
        model_fill();
        check("linit_busy_cycles", n, 72);
        check("linit_count", 32'(ALIVE_COUNT), 72);
        check("linit_level_clear_end", 32'(LEVEL_CLEAR), 0);

        request(REQ_OP_CLEAR, 7'd3, lat, alive, cnt, lclr);
        request(REQ_OP_CLEAR, 7'd50, lat, alive, cnt, lclr);
        request(REQ_OP_CLEAR, 7'd71, lat, alive, cnt, lclr);
        check("pre_restart_count", 32'(cnt), 69);

        // Restart the sweep at pointer 40 with a request pending.
        LEVEL_INIT = 1'b1;
        tick();
        LEVEL_INIT = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        LEVEL_INIT = 1'b1;
        REQ = 1'b1;
        REQ_OP = REQ_OP_QUERY;
        REQ_ADDR = 7'd3;
        tick();
        LEVEL_INIT = 1'b0;
        c = 0;
        free_n = 0;
        ack_early = 1'b0;
        RENDER_ADDR = 7'd0;
        while (BUSY && c < 1000) begin
            RENDER_ACTIVE = ((c >> 3) & 1) == 0;
            if (!RENDER_ACTIVE) free_n++;
            tick();
            if (ACK) ack_early = 1'b1;
            c++;
        end
        check("restart_cycles", c, 144);
        check("restart_free_cycles", free_n, 72);
        check("restart_no_ack", 32'(ack_early), 0);
        check("restart_count", 32'(ALIVE_COUNT), 72);
        RENDER_ACTIVE = 1'b0;
        tick();
        check("pending_ack", 32'(ACK), 1);
        check("pending_ack_alive", 32'(ACK_ALIVE), 1);
        REQ = 1'b0;
        tick();
        RENDER_ACTIVE = 1'b1;
        for (int a = 0; a < NB; a++) begin
            RENDER_ADDR = 7'(a);
            tick();
            check("restart_alive", 32'(RENDER_ALIVE), 1);
        end
        RENDER_ACTIVE = 1'b0;
        tick();

        request(REQ_OP_QUERY, 7'd100, lat, alive, cnt, lclr);
        check("q100_latency", lat, 1);
        check("q100_alive", 32'(alive), 0);
        check("q100_count", 32'(cnt), 72);
        request(REQ_OP_CLEAR, 7'd100, lat, alive, cnt, lclr);
        check("c100_latency", lat, 1);
        check("c100_alive", 32'(alive), 0);
        check("c100_count", 32'(cnt), 72);

        // Reset lands in the DONE cycle of a clear.
        REQ = 1'b1;
        REQ_OP = REQ_OP_CLEAR;
        REQ_ADDR = 7'd20;
        tick();
        RESET = 1'b1;
        #1;
        check("reset_done_ack", 32'(ACK), 0);
        REQ = 1'b0;
        tick();
        RESET = 1'b0;
        check("reset_done_ack_after", 32'(ACK), 0);
        check("reset_done_count", 32'(ALIVE_COUNT), 0);
        check("reset_done_busy", 32'(BUSY), 1);
        n = 0;
        while (BUSY && n < 500) begin
            n++;
            tick();
        end
        check("reset2_busy_cycles", n, 72);
        check("reset2_count", 32'(ALIVE_COUNT), 72);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
